// File: rtl/slice_bank_scheduler.sv
// Ping-pong slice buffer scheduler: steers 8x8 blocks into two banks,
// closes slices when full or flushed, and offers closed banks downstream.
module slice_bank_scheduler #(
    parameter int BLOCKS_PER_SLICE = 32,
    parameter int CNT_W            = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [1:0]       wr_valid,
    output logic [31:0]      wr_block_idx,
    output logic             slice_valid,
    output logic             slice_bank,
    output logic [CNT_W-1:0] slice_nblocks,
    input  logic             slice_ack,
    output logic [15:0]      slices_done
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } bank_st_e;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCKS_PER_SLICE - 1);

    bank_st_e         st_q [2];
    bank_st_e         st_d [2];
    logic [CNT_W-1:0] nblk_q [2];
    logic [CNT_W-1:0] nblk_d [2];
    logic             wb_q, wb_d;
    logic             rb_q, rb_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [15:0]      slices_done_q, slices_done_d;

    logic accept;
    logic close;
    logic ack;

    always_comb begin
        in_ready      = (st_q[wb_q] != READY);
        accept        = in_valid & in_ready;
        wr_valid      = 2'b00;
        wr_valid[wb_q] = accept;
        wr_block_idx  = 32'(fill_cnt_q);
        slice_valid   = (st_q[rb_q] == READY);
        slice_bank    = rb_q;
        slice_nblocks = nblk_q[rb_q];
        slices_done   = slices_done_q;
        ack           = slice_ack & slice_valid;
        // A flush only closes a bank that holds or is receiving a block
        close = (accept && fill_cnt_q == LAST) ||
                (flush && (accept || fill_cnt_q != '0));
    end

    always_comb begin
        st_d          = st_q;
        nblk_d        = nblk_q;
        wb_d          = wb_q;
        rb_d          = rb_q;
        fill_cnt_d    = fill_cnt_q;
        slices_done_d = slices_done_q;
        if (ack) begin
            st_d[rb_q]    = EMPTY;
            rb_d          = ~rb_q;
            slices_done_d = slices_done_q + 16'd1;
        end
        if (accept) begin
            st_d[wb_q] = FILL;
            fill_cnt_d = fill_cnt_q + 1'b1;
        end
        if (close) begin
            st_d[wb_q]   = READY;
            nblk_d[wb_q] = fill_cnt_q + CNT_W'(accept);
            wb_d         = ~wb_q;
            fill_cnt_d   = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st_q[0]       <= EMPTY;
            st_q[1]       <= EMPTY;
            nblk_q[0]     <= '0;
            nblk_q[1]     <= '0;
            wb_q          <= 1'b0;
            rb_q          <= 1'b0;
            fill_cnt_q    <= '0;
            slices_done_q <= '0;
        end else begin
            st_q          <= st_d;
            nblk_q        <= nblk_d;
            wb_q          <= wb_d;
            rb_q          <= rb_d;
            fill_cnt_q    <= fill_cnt_d;
            slices_done_q <= slices_done_d;
        end
    end

endmodule

// File: tb/tb_slice_bank_scheduler.sv
// Directed bench for slice_bank_scheduler: fill, stall, flush,
// ack/close overlap, async reset and slices_done wrap.
module tb_slice_bank_scheduler;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [1:0]  wr_valid;
    logic [31:0] wr_block_idx;
    logic        slice_valid;
    logic        slice_bank;
    logic [5:0]  slice_nblocks;
    logic        slice_ack;
    logic [15:0] slices_done;

    int total = 0;
    int bad   = 0;

    slice_bank_scheduler #(
        .BLOCKS_PER_SLICE(32),
        .CNT_W(6)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .flush(flush),
        .wr_valid(wr_valid),
        .wr_block_idx(wr_block_idx),
        .slice_valid(slice_valid),
        .slice_bank(slice_bank),
        .slice_nblocks(slice_nblocks),
        .slice_ack(slice_ack),
        .slices_done(slices_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one cycle; inputs change 1ns after the rising edge
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        flush     = 1'b0;
        slice_ack = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic put_blocks(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        #2;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0h want=1", in_ready); end
        total++; if (slice_valid !== 1'b0) begin bad++; $display("FAIL rst_slice_valid got=%0h want=0", slice_valid); end
        total++; if (wr_valid !== 2'b00) begin bad++; $display("FAIL rst_wr_valid got=%0h want=0", wr_valid); end
        total++; if (wr_block_idx !== 32'd0) begin bad++; $display("FAIL rst_idx got=%0h want=0", wr_block_idx); end
        total++; if (slice_bank !== 1'b0) begin bad++; $display("FAIL rst_slice_bank got=%0h want=0", slice_bank); end
        total++; if (slice_nblocks !== 6'd0) begin bad++; $display("FAIL rst_nblocks got=%0d want=0", slice_nblocks); end
        total++; if (slices_done !== 16'd0) begin bad++; $display("FAIL rst_done got=%0d want=0", slices_done); end
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_fill32();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            #1;
            total++; if (wr_valid !== 2'b01) begin bad++; $display("FAIL fill_wr_valid[%0d] got=%0h want=1", i, wr_valid); end
            total++; if (wr_block_idx !== 32'(i)) begin bad++; $display("FAIL fill_idx got=%0d want=%0d", wr_block_idx, i); end
            cyc();
        end
        in_valid = 1'b0;
        #1;
        total++; if (slice_valid !== 1'b1) begin bad++; $display("FAIL fill_slice_valid got=%0h want=1", slice_valid); end
        total++; if (slice_bank !== 1'b0) begin bad++; $display("FAIL fill_slice_bank got=%0h want=0", slice_bank); end
        total++; if (slice_nblocks !== 6'd32) begin bad++; $display("FAIL fill_nblocks got=%0d want=32", slice_nblocks); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_in_ready got=%0h want=1", in_ready); end
        in_valid = 1'b1;
        #1;
        total++; if (wr_valid !== 2'b10) begin bad++; $display("FAIL fill_next_bank got=%0h want=2", wr_valid); end
        total++; if (wr_block_idx !== 32'd0) begin bad++; $display("FAIL fill_next_idx got=%0d want=0", wr_block_idx); end
        cyc();
        idle();
    endtask

    task automatic test_stall();
        do_reset();
        put_blocks(64);
        in_valid = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%0h want=0", in_ready); end
        total++; if (wr_valid !== 2'b00) begin bad++; $display("FAIL stall_wr_valid got=%0h want=0", wr_valid); end
        total++; if (slice_bank !== 1'b0) begin bad++; $display("FAIL stall_bank got=%0h want=0", slice_bank); end
        cyc();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_hold got=%0h want=0", in_ready); end
        slice_ack = 1'b1;
        cyc();
        slice_ack = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%0h want=1", in_ready); end
        total++; if (wr_valid !== 2'b01) begin bad++; $display("FAIL stall_wr_bank0 got=%0h want=1", wr_valid); end
        total++; if (wr_block_idx !== 32'd0) begin bad++; $display("FAIL stall_idx got=%0d want=0", wr_block_idx); end
        total++; if (slice_bank !== 1'b1) begin bad++; $display("FAIL stall_rb got=%0h want=1", slice_bank); end
        total++; if (slices_done !== 16'd1) begin bad++; $display("FAIL stall_done got=%0d want=1", slices_done); end
        cyc();
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        put_blocks(5);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        #1;
        total++; if (slice_valid !== 1'b1) begin bad++; $display("FAIL flush_valid got=%0h want=1", slice_valid); end
        total++; if (slice_nblocks !== 6'd5) begin bad++; $display("FAIL flush_nblocks got=%0d want=5", slice_nblocks); end
        total++; if (slice_bank !== 1'b0) begin bad++; $display("FAIL flush_bank got=%0h want=0", slice_bank); end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        #1;
        total++; if (slice_nblocks !== 6'd5) begin bad++; $display("FAIL flush2_nblocks got=%0d want=5", slice_nblocks); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush2_in_ready got=%0h want=1", in_ready); end
        in_valid = 1'b1;
        #1;
        total++; if (wr_valid !== 2'b10) begin bad++; $display("FAIL flush_next_bank got=%0h want=2", wr_valid); end
        total++; if (wr_block_idx !== 32'd0) begin bad++; $display("FAIL flush_next_idx got=%0d want=0", wr_block_idx); end
        in_valid = 1'b0;
        slice_ack = 1'b1;
        cyc();
        slice_ack = 1'b0;
        #1;
        total++; if (slice_valid !== 1'b0) begin bad++; $display("FAIL flush2_noclose got=%0h want=0", slice_valid); end
        idle();
    endtask

    task automatic test_flush_accept();
        do_reset();
        put_blocks(6);
        in_valid = 1'b1;
        flush    = 1'b1;
        cyc();
        idle();
        #1;
        total++; if (slice_nblocks !== 6'd7) begin bad++; $display("FAIL flacc_nblocks got=%0d want=7", slice_nblocks); end
        total++; if (slice_valid !== 1'b1) begin bad++; $display("FAIL flacc_valid got=%0h want=1", slice_valid); end
        in_valid = 1'b1;
        #1;
        total++; if (wr_valid !== 2'b10) begin bad++; $display("FAIL flacc_wb got=%0h want=2", wr_valid); end
        total++; if (wr_block_idx !== 32'd0) begin bad++; $display("FAIL flacc_idx got=%0d want=0", wr_block_idx); end
        in_valid = 1'b0;
    endtask

    task automatic test_flush_full();
        do_reset();
        put_blocks(31);
        in_valid = 1'b1;
        flush    = 1'b1;
        cyc();
        idle();
        #1;
        total++; if (slice_nblocks !== 6'd32) begin bad++; $display("FAIL flfull_nblocks got=%0d want=32", slice_nblocks); end
        total++; if (wr_block_idx !== 32'd0) begin bad++; $display("FAIL flfull_idx got=%0d want=0", wr_block_idx); end
        slice_ack = 1'b1;
        cyc();
        slice_ack = 1'b0;
        #1;
        total++; if (slice_valid !== 1'b0) begin bad++; $display("FAIL flfull_single got=%0h want=0", slice_valid); end
        total++; if (slices_done !== 16'd1) begin bad++; $display("FAIL flfull_done got=%0d want=1", slices_done); end
        in_valid = 1'b1;
        #1;
        total++; if (wr_valid !== 2'b10) begin bad++; $display("FAIL flfull_wb got=%0h want=2", wr_valid); end
        in_valid = 1'b0;
    endtask

    task automatic test_ack_close();
        do_reset();
        put_blocks(63);
        in_valid  = 1'b1;
        slice_ack = 1'b1;
        #1;
        total++; if (wr_block_idx !== 32'd31) begin bad++; $display("FAIL ackcl_pre_idx got=%0d want=31", wr_block_idx); end
        cyc();
        idle();
        #1;
        total++; if (slice_bank !== 1'b1) begin bad++; $display("FAIL ackcl_bank got=%0h want=1", slice_bank); end
        total++; if (slice_nblocks !== 6'd32) begin bad++; $display("FAIL ackcl_nblocks got=%0d want=32", slice_nblocks); end
        total++; if (slice_valid !== 1'b1) begin bad++; $display("FAIL ackcl_valid got=%0h want=1", slice_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ackcl_in_ready got=%0h want=1", in_ready); end
        total++; if (slices_done !== 16'd1) begin bad++; $display("FAIL ackcl_done got=%0d want=1", slices_done); end
        in_valid = 1'b1;
        #1;
        total++; if (wr_valid !== 2'b01) begin bad++; $display("FAIL ackcl_wb got=%0h want=1", wr_valid); end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        put_blocks(32);
        slice_ack = 1'b1;
        cyc();
        slice_ack = 1'b0;
        put_blocks(10);
        #1;
        total++; if (wr_block_idx !== 32'd10) begin bad++; $display("FAIL rmid_pre_idx got=%0d want=10", wr_block_idx); end
        total++; if (slices_done !== 16'd1) begin bad++; $display("FAIL rmid_pre_done got=%0d want=1", slices_done); end
        reset_n = 1'b0;
        #1;
        total++; if (wr_block_idx !== 32'd0) begin bad++; $display("FAIL rmid_idx got=%0d want=0", wr_block_idx); end
        total++; if (slices_done !== 16'd0) begin bad++; $display("FAIL rmid_done got=%0d want=0", slices_done); end
        total++; if (slice_bank !== 1'b0) begin bad++; $display("FAIL rmid_bank got=%0h want=0", slice_bank); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%0h want=1", in_ready); end
        reset_n = 1'b1;
        cyc();
        in_valid = 1'b1;
        #1;
        total++; if (wr_valid !== 2'b01) begin bad++; $display("FAIL rmid_wb got=%0h want=1", wr_valid); end
        total++; if (wr_block_idx !== 32'd0) begin bad++; $display("FAIL rmid_idx2 got=%0d want=0", wr_block_idx); end
        in_valid = 1'b0;
    endtask

    task automatic test_ack_idle();
        do_reset();
        slice_ack = 1'b1;
        cyc();
        slice_ack = 1'b0;
        #1;
        total++; if (slices_done !== 16'd0) begin bad++; $display("FAIL ackidle_done got=%0d want=0", slices_done); end
        total++; if (slice_bank !== 1'b0) begin bad++; $display("FAIL ackidle_bank got=%0h want=0", slice_bank); end
    endtask

    // One-block slices closed by flush and acked the following cycle
    task automatic test_wrap();
        do_reset();
        in_valid  = 1'b1;
        flush     = 1'b1;
        slice_ack = 1'b1;
        for (int i = 0; i < 65536; i++) cyc();
        #1;
        total++; if (slices_done !== 16'hFFFF) begin bad++; $display("FAIL wrap_ffff got=%0h want=ffff", slices_done); end
        total++; if (slice_nblocks !== 6'd1) begin bad++; $display("FAIL wrap_nblocks got=%0d want=1", slice_nblocks); end
        cyc();
        idle();
        #1;
        total++; if (slices_done !== 16'd0) begin bad++; $display("FAIL wrap_zero got=%0h want=0", slices_done); end
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        test_reset();
        test_fill32();
        test_stall();
        test_flush();
        test_flush_accept();
        test_flush_full();
        test_ack_close();
        test_reset_mid();
        test_ack_idle();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
